// File: rtl/button_cond_pkg.sv
// Shared constants, default timing parameters and channel FSM state type
// for the three-button front-panel conditioner.
package button_cond_pkg;

  localparam int NUM_BTN        = 3;
  localparam int BTN_START_STOP = 0;
  localparam int BTN_SET        = 1;
  localparam int BTN_SNOOZE     = 2;

  localparam int DEF_DEBOUNCE_CYCLES = 10000;
  localparam int DEF_LONG_CYCLES     = 250000;
  localparam int DEF_REPEAT_CYCLES   = 125000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } btn_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce, press/long/repeat FSM and
// hold counter. Raw input is active-low; all outputs are active-high.
module button_channel
  import button_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic btn_n_raw,
  output logic level,
  output logic press,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES));

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  =
    HOLD_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
  localparam bit                REPEAT_EN = (REPEAT_CYCLES > 0);

  logic [1:0]        sync_n;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  btn_state_e        state;
  logic              differs;
  logic              accept;

  // accept marks the edge on which the debounced level flips
  always_comb begin
    differs = (~sync_n[1]) != level;
    accept  = differs && (db_cnt == DB_LAST);
  end

  // NOTE: all state below uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      // NOTE: sync flops reset to 1 (released), so a button held through
      // reset is re-debounced and reported as a fresh press.
      sync_n       <= 2'b11;
      db_cnt       <= '0;
      hold_cnt     <= '0;
      level        <= 1'b0;
      state        <= ST_IDLE;
      press        <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      sync_n       <= {sync_n[0], btn_n_raw};
      press        <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;

      if (!differs || accept) db_cnt <= '0;
      else                    db_cnt <= db_cnt + 1'b1;

      if (accept) level <= ~level;

      unique case (state)
        ST_IDLE: begin
          if (accept && !level) begin
            state    <= ST_PRESSED;
            hold_cnt <= '0;
            press    <= 1'b1;
          end
        end
        ST_PRESSED: begin
          // an accepted release outranks the long event on the same edge
          if (accept) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt == LONG_LAST) begin
            state      <= ST_LONG_HELD;
            hold_cnt   <= '0;
            long_pulse <= 1'b1;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (accept) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
          end else if (REPEAT_EN && (hold_cnt == REP_LAST)) begin
            hold_cnt     <= '0;
            repeat_pulse <= 1'b1;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Three independent button channels (start_stop, set, snooze) turning raw
// active-low switches into debounced levels and press/long/repeat pulses.
module button_conditioner
  import button_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_BTN-1:0] btn_n_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_channel (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .btn_n_raw   (btn_n_in[i]),
      .level       (btn_level[i]),
      .press       (btn_press[i]),
      .long_pulse  (btn_long[i]),
      .repeat_pulse(btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed scoreboard bench: two instances (repeat enabled / disabled) share
// the buttons; expected events are queued when stimulus is applied.
module tb_button_conditioner;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [2:0] btn_n;
  logic [2:0] a_level, a_press, a_long, a_rep;
  logic [2:0] b_level, b_press, b_long, b_rep;

  always #5 CLK = ~CLK;

  button_conditioner #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .btn_n_in(btn_n),
    .btn_level(a_level), .btn_press(a_press), .btn_long(a_long), .btn_repeat(a_rep)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(0)) u_dut_norep (
    .CLK(CLK), .RESET_N(RESET_N), .btn_n_in(btn_n),
    .btn_level(b_level), .btn_press(b_press), .btn_long(b_long), .btn_repeat(b_rep)
  );

  typedef struct {
    int unsigned cyc;
    logic [2:0]  level;
    logic [2:0]  press;
    logic [2:0]  lng;
    logic [2:0]  rep;
  } exp_t;

  exp_t        sb[$];
  logic [2:0]  exp_level;
  int          total = 0;
  int          bad   = 0;
  int unsigned edge_n = 0;
  int unsigned base;
  int          nb_press, nb_long, nb_rep;

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int unsigned cyc, input logic [2:0] lvl, input logic [2:0] prs,
                      input logic [2:0] lng, input logic [2:0] rep);
    exp_t ev;
    ev.cyc = cyc; ev.level = lvl; ev.press = prs; ev.lng = lng; ev.rep = rep;
    sb.push_back(ev);
  endtask

  // One rising edge, then compare both instances on the falling edge.
  task automatic step();
    exp_t ev;
    logic [2:0] ep, el, er;
    @(posedge CLK);
    edge_n++;
    @(negedge CLK);
    ep = '0; el = '0; er = '0;
    if (sb.size() > 0 && sb[0].cyc == edge_n) begin
      ev = sb.pop_front();
      exp_level = ev.level;
      ep = ev.press; el = ev.lng; er = ev.rep;
    end
    chk3("a_level",  a_level, exp_level);
    chk3("a_press",  a_press, ep);
    chk3("a_long",   a_long,  el);
    chk3("a_repeat", a_rep,   er);
    chk3("b_level",  b_level, exp_level);
    chk3("b_press",  b_press, ep);
    chk3("b_long",   b_long,  el);
    chk3("b_repeat", b_rep,   3'b000);
    nb_press += $countones(b_press);
    nb_long  += $countones(b_long);
    nb_rep   += $countones(b_rep);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    RESET_N   = 1'b0;
    btn_n     = 3'b111;
    exp_level = 3'b000;
    nb_press  = 0; nb_long = 0; nb_rep = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk3("rst_level",  a_level, 3'b000);
    chk3("rst_press",  a_press, 3'b000);
    chk3("rst_long",   a_long,  3'b000);
    chk3("rst_repeat", a_rep,   3'b000);
    RESET_N = 1'b1;
    steps(3);

    // Clean press of set: level/press at edge 6, release seen 6 edges later.
    base  = edge_n;
    btn_n = 3'b101;
    push(base + 6,  3'b010, 3'b010, 3'b000, 3'b000);
    push(base + 16, 3'b000, 3'b000, 3'b000, 3'b000);
    steps(10);
    btn_n = 3'b111;
    steps(12);
    chk_int("clean_drained", sb.size(), 0);

    // Three-cycle snooze glitch: nothing may change.
    btn_n = 3'b011;
    steps(3);
    btn_n = 3'b111;
    steps(12);
    chk_int("glitch_drained", sb.size(), 0);

    // Long hold of start_stop for 60 cycles; the repeat due on the release
    // edge (base+66) loses to the release.
    base  = edge_n;
    nb_press = 0; nb_long = 0; nb_rep = 0;
    btn_n = 3'b110;
    push(base + 6,  3'b001, 3'b001, 3'b000, 3'b000);
    push(base + 26, 3'b001, 3'b000, 3'b001, 3'b000);
    push(base + 34, 3'b001, 3'b000, 3'b000, 3'b001);
    push(base + 42, 3'b001, 3'b000, 3'b000, 3'b001);
    push(base + 50, 3'b001, 3'b000, 3'b000, 3'b001);
    push(base + 58, 3'b001, 3'b000, 3'b000, 3'b001);
    push(base + 66, 3'b000, 3'b000, 3'b000, 3'b000);
    steps(60);
    btn_n = 3'b111;
    steps(12);
    chk_int("long_drained", sb.size(), 0);
    chk_int("norep_press_count",  nb_press, 1);
    chk_int("norep_long_count",   nb_long,  1);
    chk_int("norep_repeat_count", nb_rep,   0);

    // All three buttons on the same edge.
    base  = edge_n;
    btn_n = 3'b000;
    push(base + 6,  3'b111, 3'b111, 3'b000, 3'b000);
    push(base + 16, 3'b000, 3'b000, 3'b000, 3'b000);
    steps(10);
    btn_n = 3'b111;
    steps(12);
    chk_int("simul_drained", sb.size(), 0);

    // Reset for two cycles while in LONG_HELD with the button still held.
    base  = edge_n;
    btn_n = 3'b110;
    push(base + 6,  3'b001, 3'b001, 3'b000, 3'b000);
    push(base + 26, 3'b001, 3'b000, 3'b001, 3'b000);
    steps(30);
    RESET_N = 1'b0;
    push(base + 31, 3'b000, 3'b000, 3'b000, 3'b000);
    steps(2);
    RESET_N = 1'b1;
    push(base + 38, 3'b001, 3'b001, 3'b000, 3'b000);
    push(base + 58, 3'b001, 3'b000, 3'b001, 3'b000);
    push(base + 66, 3'b001, 3'b000, 3'b000, 3'b001);
    push(base + 68, 3'b000, 3'b000, 3'b000, 3'b000);
    steps(30);
    btn_n = 3'b111;
    steps(12);
    chk_int("reset_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
